// File: rtl/wrr_arbiter_defs.sv
//------------------------------------------------------------------------------
// wrr_arbiter_defs : shared state encoding and owner-index width for the
//                    weighted round-robin packet arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wrr_arbiter_defs;

    // Owner index is 3 bits so that up to 8 requesters fit.
    localparam int c_grant_id_w = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wrr_packet_arbiter_if.sv
//------------------------------------------------------------------------------
// wrr_packet_arbiter_if : requester/downstream bundle of the packet arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wrr_packet_arbiter_if
    import wrr_arbiter_defs::*;
#(
    parameter int WIDTH       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WEIGHT_BITS = 4
) ();

    logic [WIDTH-1:0]             WRITE_REQ;
    logic [WIDTH-1:0]             HOLD_REQ;
    logic [WIDTH*DATA_WIDTH-1:0]  DATA_IN;
    logic [WIDTH*WEIGHT_BITS-1:0] WEIGHT;
    logic                         READY_OUT;
    logic [WIDTH-1:0]             READ_GRANT;
    logic                         WRITE_OUT;
    logic [DATA_WIDTH-1:0]        DATA_OUT;
    logic [c_grant_id_w-1:0]      GRANT_ID;
    logic                         BUSY;

    modport master (
        output WRITE_REQ, HOLD_REQ, DATA_IN, WEIGHT, READY_OUT,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
    );

    modport slave (
        input  WRITE_REQ, HOLD_REQ, DATA_IN, WEIGHT, READY_OUT,
        output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
    );

endinterface

`default_nettype wire

// File: rtl/rr_priority_select.sv
//------------------------------------------------------------------------------
// rr_priority_select : finds the first set request after i_last, wrapping.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_select
    import wrr_arbiter_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        i_req,
    input  logic [c_grant_id_w-1:0] i_last,
    output logic                    o_found,
    output logic [c_grant_id_w-1:0] o_index
);

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin : p_search
        int v_idx;
        o_found = 1'b0;
        o_index = '0;
        v_idx   = 0;
        for (int k = WIDTH; k >= 1; k--) begin
            v_idx = (int'(i_last) + k) % WIDTH;
            for (int j = 0; j < WIDTH; j++) begin
                if ((j == v_idx) && i_req[j]) begin
                    o_found = 1'b1;
                    o_index = c_grant_id_w'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wrr_packet_arbiter.sv
//------------------------------------------------------------------------------
// wrr_packet_arbiter : weighted round-robin arbiter moving requester words
//                      into a downstream FIFO, with packet hold.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wrr_packet_arbiter
    import wrr_arbiter_defs::*;
#(
    parameter int WIDTH       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WEIGHT_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST_B,
    wrr_packet_arbiter_if.slave bus
);

    localparam logic [c_grant_id_w-1:0] c_last_rst = c_grant_id_w'(WIDTH - 1);
    localparam logic [WEIGHT_BITS-1:0]  c_one      = WEIGHT_BITS'(1);

    arb_state_t              r_state,  w_state_nxt;
    logic [c_grant_id_w-1:0] r_sel,    w_sel_nxt;
    logic [c_grant_id_w-1:0] r_last,   w_last_nxt;
    logic [WEIGHT_BITS-1:0]  r_credit, w_credit_nxt;

    logic                    w_found;
    logic [c_grant_id_w-1:0] w_index;
    logic                    w_req_sel;
    logic                    w_hold_sel;
    logic [DATA_WIDTH-1:0]   w_data_sel;
    logic [WEIGHT_BITS-1:0]  w_weight_cand;
    logic [WEIGHT_BITS-1:0]  w_eff_weight;
    logic                    w_busy;
    logic                    w_xfer;
    logic [WIDTH-1:0]        w_read_grant;

    rr_priority_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .i_req   (bus.WRITE_REQ),
        .i_last  (r_last),
        .o_found (w_found),
        .o_index (w_index)
    );

    always_comb begin : p_owner_mux
        w_req_sel     = 1'b0;
        w_hold_sel    = 1'b0;
        w_data_sel    = '0;
        w_weight_cand = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sel == c_grant_id_w'(i)) begin
                w_req_sel  = bus.WRITE_REQ[i];
                w_hold_sel = bus.HOLD_REQ[i];
                w_data_sel = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_index == c_grant_id_w'(i)) begin
                w_weight_cand = bus.WEIGHT[i*WEIGHT_BITS +: WEIGHT_BITS];
            end
        end
    end

    // A programmed weight of zero still grants one word.
    assign w_eff_weight = (w_weight_cand == '0) ? c_one : w_weight_cand;
    assign w_busy       = (r_state == ST_GRANT);
    assign w_xfer       = w_busy && w_req_sel && bus.READY_OUT;

    always_comb begin : p_read_grant
        w_read_grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_read_grant[i] = w_xfer && (r_sel == c_grant_id_w'(i));
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_last_nxt   = r_last;
        w_credit_nxt = r_credit;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = ST_GRANT;
                    w_sel_nxt    = w_index;
                    w_credit_nxt = w_eff_weight;
                end
            end
            ST_GRANT: begin
                if (w_xfer && (r_credit != '0)) begin
                    w_credit_nxt = r_credit - c_one;
                end
                // Hold overrides both exhausted credit and a paused requester.
                if (!w_hold_sel && ((w_xfer && (r_credit <= c_one)) || !w_req_sel)) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_sel;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin : p_fsm_reg
        if (!RST_B) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_last   <= c_last_rst;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_last   <= w_last_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign bus.READ_GRANT = w_read_grant;
    assign bus.WRITE_OUT  = w_busy && w_req_sel;
    assign bus.DATA_OUT   = w_busy ? w_data_sel : '0;
    assign bus.GRANT_ID   = r_sel;
    assign bus.BUSY       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
//------------------------------------------------------------------------------
// tb_wrr_packet_arbiter : directed self-checking bench for wrr_packet_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wrr_packet_arbiter;

    localparam int WIDTH       = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int WEIGHT_BITS = 4;

    logic clk    = 1'b0;
    logic rst_b  = 1'b0;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] q_wr[$];
    logic [3:0] q_hold[$];
    logic [3:0] q_rg[$];
    logic       q_rdy[$];
    logic       q_busy[$];
    logic [3:0] seq_wt [16];

    always #5 clk = ~clk;

    wrr_packet_arbiter_if #(
        .WIDTH       (WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_BITS (WEIGHT_BITS)
    ) arb_if ();

    wrr_packet_arbiter #(
        .WIDTH       (WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_BITS (WEIGHT_BITS)
    ) u_dut (
        .CLK   (clk),
        .RST_B (rst_b),
        .bus   (arb_if.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_q();
        q_wr.delete();
        q_hold.delete();
        q_rg.delete();
        q_rdy.delete();
        q_busy.delete();
    endtask

    task automatic push(input logic [3:0] wr, input logic [3:0] hold, input logic rdy,
                        input logic [3:0] rg, input logic busy);
        q_wr.push_back(wr);
        q_hold.push_back(hold);
        q_rdy.push_back(rdy);
        q_rg.push_back(rg);
        q_busy.push_back(busy);
    endtask

    // Reset with the first row already driven, check quiet outputs, release.
    task automatic start(input logic [15:0] wt);
        @(posedge clk);
        #1;
        rst_b              = 1'b0;
        arb_if.WRITE_REQ   = q_wr[0];
        arb_if.HOLD_REQ    = q_hold[0];
        arb_if.READY_OUT   = q_rdy[0];
        arb_if.WEIGHT      = wt;
        @(negedge clk);
        check_val("rst_busy", 32'(arb_if.BUSY), 32'd0);
        check_val("rst_write_out", 32'(arb_if.WRITE_OUT), 32'd0);
        check_val("rst_read_grant", 32'(arb_if.READ_GRANT), 32'd0);
        check_val("rst_data_out", arb_if.DATA_OUT, 32'd0);
        check_val("rst_grant_id", 32'(arb_if.GRANT_ID), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic run_seq(input string tag);
        for (int k = 0; k < q_rg.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                arb_if.WRITE_REQ = q_wr[k];
                arb_if.HOLD_REQ  = q_hold[k];
                arb_if.READY_OUT = q_rdy[k];
            end
            @(negedge clk);
            check_val({tag, "_read_grant"}, 32'(arb_if.READ_GRANT), 32'(q_rg[k]));
            check_val({tag, "_busy"}, 32'(arb_if.BUSY), 32'(q_busy[k]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (arb_if.READ_GRANT != '0) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (arb_if.READ_GRANT[j]) begin
                        check_val("mon_data_out", arb_if.DATA_OUT, 32'hC0DE_0000 + 32'(j));
                        check_val("mon_grant_id", 32'(arb_if.GRANT_ID), 32'(j));
                    end
                end
            end else if (!arb_if.BUSY) begin
                check_val("mon_idle_data", arb_if.DATA_OUT, 32'd0);
                check_val("mon_idle_write", 32'(arb_if.WRITE_OUT), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] v_wr;
        logic [3:0] v_hold;
        logic [3:0] v_rg;
        logic       v_busy;
        logic       v_word;

        arb_if.WRITE_REQ = '0;
        arb_if.HOLD_REQ  = '0;
        arb_if.WEIGHT    = '0;
        arb_if.READY_OUT = 1'b0;
        arb_if.DATA_IN   = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        seq_wt = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4,
                   4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Equal weights: 0,1,2,3,0 with a bubble between words.
        clear_q();
        for (int i = 0; i < 10; i++) begin
            v_rg = (i % 2 == 1) ? 4'(1 << ((i / 2) % 4)) : 4'h0;
            push(4'hF, 4'h0, 1'b1, v_rg, (i % 2 == 1));
        end
        start(16'h1111);
        run_seq("rr_equal");

        // Weights {3,1,0,2}: 3,1,1,2 words per round.
        clear_q();
        for (int i = 0; i < 16; i++) begin
            push(4'hF, 4'h0, 1'b1, seq_wt[i], (seq_wt[i] != 4'h0));
        end
        start(16'h2013);
        run_seq("rr_weight");

        // Requester 2 holds for 6 gapped words while requester 0 waits.
        clear_q();
        for (int k = 0; k < 19; k++) begin
            v_word = (k >= 1) && (k <= 16) && ((k - 1) % 3 == 0);
            v_wr   = (k == 0) ? 4'b0100 : (v_word ? 4'b0101 : 4'b0001);
            v_hold = (k <= 15) ? 4'b0100 : 4'b0000;
            v_rg   = v_word ? 4'b0100 : ((k == 18) ? 4'b0001 : 4'b0000);
            v_busy = ((k >= 1) && (k <= 16)) || (k == 18);
            push(v_wr, v_hold, 1'b1, v_rg, v_busy);
        end
        start(16'h0200);
        run_seq("hold");

        // READY_OUT 1,0,0,1 with weight 2: two words then release.
        clear_q();
        push(4'h2, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'h2, 4'h0, 1'b1, 4'h2, 1'b1);
        push(4'h2, 4'h0, 1'b0, 4'h0, 1'b1);
        push(4'h2, 4'h0, 1'b0, 4'h0, 1'b1);
        push(4'h2, 4'h0, 1'b1, 4'h2, 1'b1);
        push(4'h2, 4'h0, 1'b1, 4'h0, 1'b0);
        start(16'h0020);
        run_seq("stall_w2");

        // Same with weight 3: stalls must not eat credit.
        clear_q();
        push(4'h2, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'h2, 4'h0, 1'b1, 4'h2, 1'b1);
        push(4'h2, 4'h0, 1'b0, 4'h0, 1'b1);
        push(4'h2, 4'h0, 1'b0, 4'h0, 1'b1);
        push(4'h2, 4'h0, 1'b1, 4'h2, 1'b1);
        push(4'h2, 4'h0, 1'b1, 4'h2, 1'b1);
        push(4'h2, 4'h0, 1'b1, 4'h0, 1'b0);
        start(16'h0030);
        run_seq("stall_w3");

        // Asynchronous reset in the middle of requester 1's packet.
        clear_q();
        push(4'hF, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'hF, 4'h0, 1'b1, 4'h1, 1'b1);
        push(4'hF, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'hF, 4'h0, 1'b1, 4'h2, 1'b1);
        start(16'h0030);
        run_seq("pre_arst");
        #2;
        rst_b = 1'b0;
        #1;
        check_val("arst_write_out", 32'(arb_if.WRITE_OUT), 32'd0);
        check_val("arst_read_grant", 32'(arb_if.READ_GRANT), 32'd0);
        check_val("arst_busy", 32'(arb_if.BUSY), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        clear_q();
        push(4'hF, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'hF, 4'h0, 1'b1, 4'h1, 1'b1);
        run_seq("post_arst");

        // Sole requester 3: wrap search re-grants it after each bubble.
        clear_q();
        push(4'h8, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'h8, 4'h0, 1'b1, 4'h8, 1'b1);
        push(4'h8, 4'h0, 1'b1, 4'h0, 1'b0);
        push(4'h8, 4'h0, 1'b1, 4'h8, 1'b1);
        push(4'h8, 4'h0, 1'b1, 4'h0, 1'b0);
        start(16'h0000);
        run_seq("wrap");

        // HOLD_REQ without WRITE_REQ never wins.
        clear_q();
        for (int i = 0; i < 3; i++) begin
            push(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);
        end
        start(16'h1111);
        run_seq("hold_only");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
